run_controller: RTL and testbench
=================================

Name: run_controller

Overview:
- Host-side initiator for the core's req/done run interface.
- Holds the core in reset and preloads its data memory from a byte stream, then pulses `core_req` and waits for `core_done` under a timeout.
- On completion it streams a result window of data memory back out and returns to idle.
- Sits between the test/host fabric and the core; owns the data-memory port whenever the core is idle.

Parameters:
- AW, 8, data memory address width.
- LOAD_N, 64, number of bytes preloaded starting at address 0 (1..2^AW).
- RES_BASE, 64, first data-memory address of the result window.
- RES_N, 32, number of result bytes drained (RES_BASE+RES_N <= 2^AW).
- TO_W, 16, timeout counter width; timeout fires at 2^TO_W-1 run cycles.

Ports:
- clk, input, 1, clock.
- reset, input, 1, synchronous active-high reset.
- start, input, 1, begin a load/run/drain sequence (sampled in IDLE only).
- ld_valid, input, 1, preload byte valid.
- ld_data, input, 8, preload byte.
- ld_ready, output, 1, preload byte accepted when ld_valid&ld_ready.
- mem_sel, output, 1, 1 = controller owns data-memory port.
- mem_wr_en, output, 1, data-memory write strobe.
- mem_addr, output, AW, data-memory address.
- mem_wr_data, output, 8, data-memory write data.
- mem_rd_data, input, 8, data-memory read data (combinational read of mem_addr).
- core_reset, output, 1, holds core in reset.
- core_req, output, 1, one-cycle run request to core.
- core_done, input, 1, core completion (level).
- res_valid, output, 1, result byte valid.
- res_data, output, 8, result byte.
- res_ready, input, 1, result byte consumed when res_valid&res_ready.
- busy, output, 1, state != IDLE.
- finished, output, 1, one-cycle pulse at sequence end.
- timeout, output, 1, sticky: last run timed out; cleared on next start.
- cyc_cnt, output, 32, run cycle count (optional feature).

Behaviour:
- Reset (sync, any state):
  - state=IDLE, core_reset=1, mem_sel=0, mem_addr=0.
  - Strobes (mem_wr_en, core_req, ld_ready, res_valid, finished) = 0.
  - timeout=0, cyc_cnt=0, run counter=0.
  - A reset mid-sequence abandons it with no finished pulse.
- States: IDLE, LOAD, LAUNCH, RUN, DRAIN, FINISH.
- IDLE:
  - core_reset=1. All strobes are 0.
  - On start=1: clear timeout, mem_addr=0, go to LOAD.
  - start is ignored in every other state.
- LOAD:
  - mem_sel=1, ld_ready=1.
  - On each handshake, same cycle: mem_wr_en=1, mem_wr_data=ld_data, write to mem_addr. Next cycle: mem_addr+1.
  - After the LOAD_N-th handshake go to LAUNCH. No stall limit.
- LAUNCH (1 cycle): core_reset=0, mem_sel=0, core_req=1, run counter=0. Go to RUN.
- RUN:
  - core_reset=0, mem_sel=0. Run counter increments each cycle.
  - core_done=1: go to DRAIN, mem_addr=RES_BASE.
  - Counter reaches 2^TO_W-1 with core_done=0: set timeout=1, go to FINISH; no drain.
  - If both happen in the same cycle, done wins.
- DRAIN:
  - core_reset=1 (freezes core), mem_sel=1.
  - res_valid=1, res_data=mem_rd_data.
  - res_data must be stable while res_valid=1 and res_ready=0.
  - On handshake mem_addr+1. After the RES_N-th handshake go to FINISH.
- FINISH (1 cycle): finished=1, core_reset=1, mem_sel=0. Go to IDLE.
- Latency: LAUNCH follows the last load handshake by 1 cycle; first res_valid is the cycle after core_done is seen.
- Address arithmetic is AW-bit with no wrap; the parameter constraints guarantee this.
- The load and result counters are sized $clog2 of their limit plus 1.

Optional Feature:
- Macro: RUN_CYCLE_COUNT_EN.
- Defined: a 32-bit counter runs from LAUNCH through the RUN cycle that sees core_done or timeout. cyc_cnt holds that value from then until the next start, which clears it.
- Undefined: cyc_cnt is tied to 0 and no counter logic is present.

Decomposition:
- Shared package run_ctl_pkg holds:
  - the state enum typedef run_state_t;
  - default constants for LOAD_N, RES_BASE, RES_N.
- One natural sub-module, byte_stream_port: the valid/ready handshake plus address/count counter. It is instantiated twice, once for LOAD and once for DRAIN.

Test Plan:
- Basic run: reset, start, stream bytes 0x00..0x3F with ld_valid always high; core model asserts done 20 cycles after req.
  - Expect 64 writes at addresses 0..63 and one core_req pulse.
  - Expect 32 res bytes equal to mem[64..95], then a finished pulse and busy=0.
- Backpressure: ld_valid toggles every other cycle; res_ready is low 3 of every 4 cycles.
  - Expect no lost or duplicated bytes and res_data stable during stalls.
- Timeout: TO_W=4, core never asserts done.
  - Expect timeout=1 after 15 RUN cycles, finished pulse, zero res_valid.
  - A following start clears timeout.
- Reset mid-sequence: assert reset during DRAIN after 5 bytes.
  - Expect IDLE next cycle, core_reset=1, no finished pulse.
  - A new start works normally.
- Start ignored while busy: pulse start during RUN.
  - Expect no restart and mem_addr unaffected.
- RUN_CYCLE_COUNT_EN defined, done 20 cycles after req: expect cyc_cnt=21. Undefined: expect cyc_cnt=0.

Source files
------------

// File: rtl/run_ctl_pkg.sv
// Shared types and default geometry for the run controller.
// The optional cycle counter is enabled by defining RUN_CYCLE_COUNT_EN.
package run_ctl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_LAUNCH,
    ST_RUN,
    ST_DRAIN,
    ST_FINISH
  } run_state_t;

  localparam int unsigned DEF_LOAD_N   = 64;
  localparam int unsigned DEF_RES_BASE = 64;
  localparam int unsigned DEF_RES_N    = 32;

endpackage

// File: rtl/byte_stream_port.sv
// One side of a valid/ready byte stream: detects the handshake and walks an
// address/count pair from BASE for N transfers.
module byte_stream_port #(
  parameter int unsigned AW   = 8,
  parameter int unsigned N    = 64,
  parameter int unsigned BASE = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear_i,
  input  logic          active_i,
  input  logic          peer_i,
  output logic          hs_o,
  output logic          last_o,
  output logic [AW-1:0] addr_o
);

  localparam int unsigned   CW     = $clog2(N) + 1;
  localparam logic [AW-1:0] BASE_A = AW'(BASE);
  localparam logic [CW-1:0] LAST_C = CW'(N - 1);
  localparam logic [CW-1:0] ONE_C  = CW'(1);
  localparam logic [AW-1:0] ONE_A  = AW'(1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;

  assign hs_o   = active_i & peer_i;
  assign last_o = (cnt_q == LAST_C);
  assign addr_o = addr_q;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    cnt_d  = cnt_q;
    addr_d = addr_q;
    if (clear_i) begin
      cnt_d  = '0;
      addr_d = BASE_A;
    end else if (hs_o) begin
      cnt_d  = cnt_q + ONE_C;
      addr_d = addr_q + ONE_A;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      addr_q <= BASE_A;
    end else begin
      cnt_q  <= cnt_d;
      addr_q <= addr_d;
    end
  end

endmodule

// File: rtl/run_controller.sv
// Host-side load/run/drain sequencer for the core's req/done interface.
// Define RUN_CYCLE_COUNT_EN to expose the run cycle count on cyc_cnt.
module run_controller
  import run_ctl_pkg::*;
#(
  parameter int unsigned AW       = 8,
  parameter int unsigned LOAD_N   = DEF_LOAD_N,
  parameter int unsigned RES_BASE = DEF_RES_BASE,
  parameter int unsigned RES_N    = DEF_RES_N,
  parameter int unsigned TO_W     = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          ld_valid,
  input  logic [7:0]    ld_data,
  output logic          ld_ready,
  output logic          mem_sel,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wr_data,
  input  logic [7:0]    mem_rd_data,
  output logic          core_reset,
  output logic          core_req,
  input  logic          core_done,
  output logic          res_valid,
  output logic [7:0]    res_data,
  input  logic          res_ready,
  output logic          busy,
  output logic          finished,
  output logic          timeout,
  output logic [31:0]   cyc_cnt
);

  // Last counter value before the timeout value 2^TO_W-1 is reached.
  localparam logic [TO_W-1:0] TO_LAST = ~TO_W'(1);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

  run_state_t      state_q, state_d;
  logic [TO_W-1:0] run_cnt_q, run_cnt_d;
  logic            timeout_q, timeout_d;

  logic            start_go, run_done, run_expire;
  logic            ld_hs, ld_last, rs_hs, rs_last;
  logic [AW-1:0]   ld_addr, rs_addr;

  assign start_go   = (state_q == ST_IDLE) && start;
  assign run_done   = (state_q == ST_RUN) && core_done;
  assign run_expire = (state_q == ST_RUN) && !core_done && (run_cnt_q == TO_LAST);

  byte_stream_port #(.AW(AW), .N(LOAD_N), .BASE(0)) u_load_port (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (start_go),
    .active_i (state_q == ST_LOAD),
    .peer_i   (ld_valid),
    .hs_o     (ld_hs),
    .last_o   (ld_last),
    .addr_o   (ld_addr)
  );

  byte_stream_port #(.AW(AW), .N(RES_N), .BASE(RES_BASE)) u_drain_port (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (run_done),
    .active_i (state_q == ST_DRAIN),
    .peer_i   (res_ready),
    .hs_o     (rs_hs),
    .last_o   (rs_last),
    .addr_o   (rs_addr)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start)             state_d = ST_LOAD;
      ST_LOAD:   if (ld_hs && ld_last)  state_d = ST_LAUNCH;
      ST_LAUNCH:                        state_d = ST_RUN;
      ST_RUN: begin
        if (core_done)                  state_d = ST_DRAIN;
        else if (run_expire)            state_d = ST_FINISH;
      end
      ST_DRAIN:  if (rs_hs && rs_last)  state_d = ST_FINISH;
      ST_FINISH:                        state_d = ST_IDLE;
      default:                          state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    core_reset = 1'b1;
    mem_sel    = 1'b0;
    ld_ready   = 1'b0;
    mem_wr_en  = 1'b0;
    core_req   = 1'b0;
    res_valid  = 1'b0;
    finished   = 1'b0;
    unique case (state_q)
      ST_LOAD: begin
        mem_sel   = 1'b1;
        ld_ready  = 1'b1;
        mem_wr_en = ld_hs;
      end
      ST_LAUNCH: begin
        core_reset = 1'b0;
        core_req   = 1'b1;
      end
      ST_RUN:    core_reset = 1'b0;
      ST_DRAIN: begin
        mem_sel   = 1'b1;
        res_valid = 1'b1;
      end
      ST_FINISH: finished = 1'b1;
      default: ;
    endcase
  end

  // The drain address only moves on a handshake, which keeps res_data stable under stall.
  assign mem_addr    = (state_q == ST_DRAIN) ? rs_addr : ld_addr;
  assign mem_wr_data = ld_data;
  assign res_data    = mem_rd_data;
  assign busy        = (state_q != ST_IDLE);
  assign timeout     = timeout_q;

  always_comb begin
    run_cnt_d = run_cnt_q;
    timeout_d = timeout_q;
    if (state_q == ST_LAUNCH)    run_cnt_d = '0;
    else if (state_q == ST_RUN)  run_cnt_d = run_cnt_q + TO_ONE;
    if (start_go)                timeout_d = 1'b0;
    else if (run_expire)         timeout_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      run_cnt_q <= run_cnt_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef RUN_CYCLE_COUNT_EN
  logic [31:0] cyc_cnt_q, cyc_cnt_d;

  // Counts LAUNCH plus every RUN cycle, so it freezes on the cycle that ends the run.
  always_comb begin
    cyc_cnt_d = cyc_cnt_q;
    if (start_go)
      cyc_cnt_d = '0;
    else if ((state_q == ST_LAUNCH) || (state_q == ST_RUN))
      cyc_cnt_d = cyc_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) cyc_cnt_q <= '0;
    else       cyc_cnt_q <= cyc_cnt_d;
  end

  assign cyc_cnt = cyc_cnt_q;
`else
  assign cyc_cnt = '0;
`endif

endmodule

// File: tb/tb_run_controller.sv
// Directed bench for run_controller: a default-geometry instance for load/run/drain
// scenarios and a TO_W=4 instance for the timeout path.
module tb_run_controller;

  localparam int DONE_DLY = 20;
`ifdef RUN_CYCLE_COUNT_EN
  localparam int EXP_CYC    = DONE_DLY + 1;
  localparam int EXP_TO_CYC = 16;
`else
  localparam int EXP_CYC    = 0;
  localparam int EXP_TO_CYC = 0;
`endif

  int total = 0;
  int bad   = 0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, ld_valid = 1'b0, core_done = 1'b0, res_ready = 1'b0;
  logic [7:0]  ld_data = 8'h00;
  logic        ld_ready, mem_sel, mem_wr_en, core_reset, core_req, res_valid;
  logic        busy, finished, timeout;
  logic [7:0]  mem_addr, mem_wr_data, mem_rd_data, res_data;
  logic [31:0] cyc_cnt;

  logic        t_start = 1'b0, t_ld_valid = 1'b0, t_core_done = 1'b0, t_res_ready = 1'b0;
  logic [7:0]  t_ld_data = 8'h00;
  logic        t_ld_ready, t_mem_sel, t_mem_wr_en, t_core_reset, t_core_req, t_res_valid;
  logic        t_busy, t_finished, t_timeout;
  logic [7:0]  t_mem_addr, t_mem_wr_data, t_mem_rd_data, t_res_data;
  logic [31:0] t_cyc_cnt;

  always #5 clk = ~clk;

  run_controller u_dut (
    .clk(clk), .reset(reset), .start(start), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .mem_sel(mem_sel), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data), .core_reset(core_reset),
    .core_req(core_req), .core_done(core_done), .res_valid(res_valid), .res_data(res_data),
    .res_ready(res_ready), .busy(busy), .finished(finished), .timeout(timeout),
    .cyc_cnt(cyc_cnt)
  );

  run_controller #(.AW(8), .LOAD_N(4), .RES_BASE(8), .RES_N(2), .TO_W(4)) u_to (
    .clk(clk), .reset(reset), .start(t_start), .ld_valid(t_ld_valid), .ld_data(t_ld_data),
    .ld_ready(t_ld_ready), .mem_sel(t_mem_sel), .mem_wr_en(t_mem_wr_en), .mem_addr(t_mem_addr),
    .mem_wr_data(t_mem_wr_data), .mem_rd_data(t_mem_rd_data), .core_reset(t_core_reset),
    .core_req(t_core_req), .core_done(t_core_done), .res_valid(t_res_valid),
    .res_data(t_res_data), .res_ready(t_res_ready), .busy(t_busy), .finished(t_finished),
    .timeout(t_timeout), .cyc_cnt(t_cyc_cnt)
  );

  // Data memory model: whole-array fill stands in for the core producing results.
  logic [7:0] mem [256];
  logic       fill_en = 1'b0;
  logic [7:0] fill_seed = 8'h00;

  function automatic logic [7:0] fill_val(input int a, input logic [7:0] s);
    return 8'(a * 7) ^ s;
  endfunction

  always @(posedge clk) begin
    if (fill_en) begin
      for (int i = 0; i < 256; i++) mem[i] <= fill_val(i, fill_seed);
    end else if (mem_sel && mem_wr_en) begin
      mem[mem_addr] <= mem_wr_data;
    end
  end

  assign mem_rd_data   = mem[mem_addr];
  assign t_mem_rd_data = t_mem_addr;

  task automatic fill_mem(input logic [7:0] seed);
    @(posedge clk); #1;
    fill_seed = seed;
    fill_en   = 1'b1;
    @(posedge clk); #1;
    fill_en   = 1'b0;
  endtask

  // One full start/load/run/drain sequence with optional backpressure, a start poke
  // during RUN, or a reset after abort_at result handshakes.
  task automatic do_sequence(input string name, input bit bp, input bit poke,
                             input int abort_at, input logic [7:0] ld_xor,
                             input logic [7:0] seed);
    int cyc = 0, ld_idx = 0, res_idx = 0, req_cnt = 0, req_cyc = -1, last_wr = -1;
    int first_rv = -1, fin = 0, fin_cyc = -1, abort_cyc = -1;
    bit prev_stall = 1'b0, ended = 1'b0;
    logic [7:0] prev_data = 8'h00, exp_b;

    fill_mem(seed);
    while (cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      start     = (cyc == 1) || (poke && req_cyc >= 0 && cyc == req_cyc + 5);
      ld_valid  = bp ? (cyc % 2 == 1) : 1'b1;
      ld_data   = ld_idx[7:0] ^ ld_xor;
      res_ready = bp ? (cyc % 4 == 3) : 1'b1;
      if (req_cyc >= 0 && cyc == req_cyc + DONE_DLY) core_done = 1'b1;
      reset = 1'b0;
      if (abort_at > 0 && abort_cyc < 0 && res_idx >= abort_at) begin
        reset     = 1'b1;
        abort_cyc = cyc;
      end

      @(negedge clk);
      if (mem_wr_en) begin
        exp_b = ld_idx[7:0] ^ ld_xor;
        total++;
        if (mem_sel !== 1'b1 || mem_addr !== ld_idx[7:0] || mem_wr_data !== exp_b) begin
          bad++;
          $display("FAIL %s wr: sel=%b addr=%0d data=%h exp addr=%0d data=%h",
                   name, mem_sel, mem_addr, mem_wr_data, ld_idx, exp_b);
        end
        ld_idx++;
        last_wr = cyc;
      end
      if (core_req) begin
        req_cnt++;
        if (req_cyc < 0) req_cyc = cyc;
      end
      if (res_valid) begin
        core_done = 1'b0;
        if (first_rv < 0) first_rv = cyc;
        exp_b = fill_val(64 + res_idx, seed);
        total++;
        if (res_data !== exp_b || mem_sel !== 1'b1 || core_reset !== 1'b1) begin
          bad++;
          $display("FAIL %s res[%0d]: got %h sel=%b crst=%b exp %h sel=1 crst=1",
                   name, res_idx, res_data, mem_sel, core_reset, exp_b);
        end
        if (prev_stall) begin
          total++;
          if (res_data !== prev_data) begin
            bad++;
            $display("FAIL %s stall_stable: got %h exp %h", name, res_data, prev_data);
          end
        end
        prev_stall = !res_ready;
        prev_data  = res_data;
        if (res_ready) res_idx++;
      end else begin
        prev_stall = 1'b0;
      end
      if (poke && req_cyc >= 0 && cyc == req_cyc + 6) begin
        total++;
        if (busy !== 1'b1 || ld_ready !== 1'b0 || mem_addr !== 8'd64 || mem_sel !== 1'b0) begin
          bad++;
          $display("FAIL %s poke: busy=%b ld_ready=%b addr=%0d sel=%b exp 1 0 64 0",
                   name, busy, ld_ready, mem_addr, mem_sel);
        end
      end
      if (finished) begin
        fin++;
        fin_cyc = cyc;
        total++;
        if (core_reset !== 1'b1 || mem_sel !== 1'b0) begin
          bad++;
          $display("FAIL %s fin_outs: crst=%b sel=%b exp 1 0", name, core_reset, mem_sel);
        end
      end
      if (abort_cyc >= 0 && cyc == abort_cyc + 1) begin
        total++;
        if (busy !== 1'b0 || core_reset !== 1'b1 || mem_sel !== 1'b0 || res_valid !== 1'b0 ||
            timeout !== 1'b0 || cyc_cnt !== 32'd0) begin
          bad++;
          $display("FAIL %s abort_idle: busy=%b crst=%b sel=%b rv=%b to=%b cc=%0d exp 0 1 0 0 0 0",
                   name, busy, core_reset, mem_sel, res_valid, timeout, cyc_cnt);
        end
      end
      if (abort_cyc >= 0 && cyc == abort_cyc + 4) begin
        ended = 1'b1;
        break;
      end
      if (fin_cyc >= 0 && cyc == fin_cyc + 1) begin
        total++;
        if (busy !== 1'b0) begin
          bad++;
          $display("FAIL %s busy_after: got %b exp 0", name, busy);
        end
        ended = 1'b1;
        break;
      end
    end
    start = 1'b0; ld_valid = 1'b0; res_ready = 1'b0; core_done = 1'b0; reset = 1'b0;

    total++;
    if (!ended) begin
      bad++;
      $display("FAIL %s budget: sequence did not end, got cyc=%0d exp end", name, cyc);
    end
    if (abort_at > 0) begin
      total++;
      if (fin !== 0) begin
        bad++;
        $display("FAIL %s abort_nofin: got %0d exp 0", name, fin);
      end
    end else begin
      total++;
      if (fin !== 1 || ld_idx !== 64 || res_idx !== 32 || req_cnt !== 1) begin
        bad++;
        $display("FAIL %s counts: fin=%0d ld=%0d res=%0d req=%0d exp 1 64 32 1",
                 name, fin, ld_idx, res_idx, req_cnt);
      end
      total++;
      if (req_cyc !== last_wr + 1 || first_rv !== req_cyc + DONE_DLY + 1) begin
        bad++;
        $display("FAIL %s latency: req=%0d rv=%0d exp req=%0d rv=%0d",
                 name, req_cyc, first_rv, last_wr + 1, req_cyc + DONE_DLY + 1);
      end
      total++;
      if (timeout !== 1'b0 || cyc_cnt !== 32'(EXP_CYC)) begin
        bad++;
        $display("FAIL %s end_regs: to=%b cc=%0d exp 0 %0d", name, timeout, cyc_cnt, EXP_CYC);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL rst busy: got %b exp 0", busy); end
    total++;
    if (core_reset !== 1'b1) begin bad++; $display("FAIL rst core_reset: got %b exp 1", core_reset); end
    total++;
    if (mem_sel !== 1'b0 || mem_addr !== 8'd0) begin
      bad++; $display("FAIL rst mem: sel=%b addr=%0d exp 0 0", mem_sel, mem_addr);
    end
    total++;
    if ({mem_wr_en, core_req, ld_ready, res_valid, finished} !== 5'b0) begin
      bad++;
      $display("FAIL rst strobes: got %b exp 00000", {mem_wr_en, core_req, ld_ready, res_valid, finished});
    end
    total++;
    if (timeout !== 1'b0 || cyc_cnt !== 32'd0) begin
      bad++; $display("FAIL rst regs: to=%b cc=%0d exp 0 0", timeout, cyc_cnt);
    end
    total++;
    if (t_busy !== 1'b0 || t_core_reset !== 1'b1 || t_timeout !== 1'b0) begin
      bad++; $display("FAIL rst t_dut: busy=%b crst=%b to=%b exp 0 1 0", t_busy, t_core_reset, t_timeout);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    do_sequence("basic", 1'b0, 1'b0, 0, 8'h00, 8'h3C);
  endtask

  task automatic test_start_ignored();
    do_sequence("start_ignored", 1'b0, 1'b1, 0, 8'h00, 8'h5A);
  endtask

  task automatic test_backpressure();
    do_sequence("backpressure", 1'b1, 1'b0, 0, 8'hA5, 8'hC3);
  endtask

  task automatic test_reset_mid();
    do_sequence("reset_mid", 1'b0, 1'b0, 5, 8'h00, 8'h11);
    do_sequence("restart", 1'b0, 1'b0, 0, 8'h0F, 8'h77);
  endtask

  task automatic test_timeout();
    int cyc = 0, req_cyc = -1, fin_cyc = -1, rv = 0, s2 = -1;
    bit ended = 1'b0;
    t_ld_valid  = 1'b1;
    t_res_ready = 1'b1;
    while (cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      t_start   = (cyc == 1) || (fin_cyc >= 0 && cyc == fin_cyc + 3);
      t_ld_data = cyc[7:0];
      if (fin_cyc >= 0 && cyc == fin_cyc + 3) s2 = cyc;
      @(negedge clk);
      if (t_res_valid) rv++;
      if (t_core_req && req_cyc < 0) req_cyc = cyc;
      if (t_finished && fin_cyc < 0) begin
        fin_cyc = cyc;
        total++;
        if (req_cyc < 0 || fin_cyc !== req_cyc + 16) begin
          bad++; $display("FAIL to fin_time: got %0d exp %0d", fin_cyc, req_cyc + 16);
        end
        total++;
        if (t_timeout !== 1'b1 || rv !== 0) begin
          bad++; $display("FAIL to flags: to=%b res_valid_cnt=%0d exp 1 0", t_timeout, rv);
        end
        total++;
        if (t_cyc_cnt !== 32'(EXP_TO_CYC)) begin
          bad++; $display("FAIL to cyc_cnt: got %0d exp %0d", t_cyc_cnt, EXP_TO_CYC);
        end
      end
      if (fin_cyc >= 0 && cyc == fin_cyc + 2) begin
        total++;
        if (t_timeout !== 1'b1 || t_busy !== 1'b0) begin
          bad++; $display("FAIL to sticky: to=%b busy=%b exp 1 0", t_timeout, t_busy);
        end
      end
      if (s2 >= 0 && cyc == s2 + 1) begin
        total++;
        if (t_timeout !== 1'b0 || t_busy !== 1'b1 || t_cyc_cnt !== 32'd0) begin
          bad++;
          $display("FAIL to restart_clear: to=%b busy=%b cc=%0d exp 0 1 0", t_timeout, t_busy, t_cyc_cnt);
        end
        ended = 1'b1;
        break;
      end
    end
    t_start = 1'b0;
    total++;
    if (!ended) begin
      bad++; $display("FAIL to budget: got cyc=%0d exp end", cyc);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_start_ignored();
    test_backpressure();
    test_reset_mid();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
